button_debounce: RTL and testbench

//   Cleans one raw, asynchronous board push-button into a glitch-free level synchronous to clk.

---
 rtl/button_debounce_pkg.sv | 18 +
 rtl/button_debounce_sync_2ff.sv | 31 +++
 rtl/button_debounce.sv | 88 ++++++++
 tb/tb_button_debounce.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared state encoding and timing constants for button debouncing
package button_debounce_pkg;

  // Encoding chosen so that bit 1 is the debounced level and bit 0 marks qualification.
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_e;

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  // 10 ms at 100 MHz; top levels derive their qualification window from this.
  localparam int unsigned DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// rtl/button_debounce_sync_2ff.sv - two-flop synchronizer for asynchronous board inputs
module button_debounce_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync0_d, sync0_q;
  logic sync1_d, sync1_q;

  // Next values: shift the raw input through two stages; only sync0 may go metastable.
  always_comb begin
    sync0_d = d;
    sync1_d = sync0_q;
  end

  // Synchronizer stages, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
    end
  end

  assign q = sync1_q;

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizer plus counter-qualified FSM producing a clean button level
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out,
  output logic busy
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  button_debounce_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );

  // Next-state logic: the glitch test on s is checked before the terminal count,
  // so a toggle on the final qualification cycle still aborts the transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_RISE;
          cnt_d   = '0;
        end
      end
      S_RISE: begin
        if (!s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_FALL;
          cnt_d   = '0;
        end
      end
      S_FALL: begin
        if (s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // State and qualification counter; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Each output is a single state bit, so neither can glitch.
  assign btn_out = state_q[1];
  assign busy    = state_q[0];

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - scoreboard bench for button_debounce with STABLE_CYCLES=4
module tb_button_debounce;

  typedef struct {
    logic  out;
    logic  busy;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_out;
  logic busy;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 1'b0;

  // downstream rising-edge detector model
  logic prev_out = 1'b0;
  logic pulse;
  int   pulse_cycles = 0;
  bit   count_pulses = 1'b0;

  button_debounce #(.STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .btn_out (btn_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prev_out <= btn_out;
  assign pulse = btn_out & ~prev_out;

  // monitor: after each edge, pop the expected outputs for that edge and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (count_pulses && pulse) pulse_cycles++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (btn_out !== e.out || busy !== e.busy) begin
          bad++;
          $display("FAIL %s: got btn_out=%b busy=%b, need btn_out=%b busy=%b",
                   e.tag, btn_out, busy, e.out, e.busy);
        end
      end
    end
  end

  task automatic drive(input bit r, input bit b, input bit eo, input bit eb, input string tag);
    exp_t e;
    @(posedge clk);
    #2;
    rst    = r;
    btn_in = b;
    e.out  = eo;
    e.busy = eb;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic press_clean(input string tag);
    for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, tag);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, tag);
    drive(0, 1, 1, 0, tag);
    drive(0, 1, 1, 0, tag);
  endtask

  task automatic release_clean(input string tag);
    for (int i = 0; i < 2; i++) drive(0, 0, 1, 0, tag);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, tag);
    drive(0, 0, 0, 0, tag);
    drive(0, 0, 0, 0, tag);
  endtask

  task automatic bounce_press(input string tag);
    drive(0, 1, 0, 0, tag);  // e1
    drive(0, 0, 0, 0, tag);  // e2
    drive(0, 1, 0, 1, tag);  // e3 RISE
    drive(0, 1, 0, 0, tag);  // e4 back to LOW
    drive(0, 0, 0, 1, tag);  // e5 RISE
    drive(0, 1, 0, 1, tag);  // e6
    drive(0, 1, 0, 0, tag);  // e7 LOW
    drive(0, 1, 0, 1, tag);  // e8 RISE
    drive(0, 1, 0, 1, tag);  // e9
    drive(0, 1, 0, 1, tag);  // e10
    drive(0, 1, 0, 1, tag);  // e11
    drive(0, 1, 1, 0, tag);  // e12 HIGH
    drive(0, 1, 1, 0, tag);
  endtask

  initial begin
    // 1: reset with button held, then full qualification
    drive(1, 1, 0, 0, "reset_hold");
    drive(1, 1, 0, 0, "reset_hold");
    press_clean("reset_release_press");

    // 4: short low glitch while HIGH
    drive(0, 0, 1, 0, "release_glitch");  // e1
    drive(0, 0, 1, 0, "release_glitch");  // e2
    drive(0, 0, 1, 1, "release_glitch");  // e3 FALL
    drive(0, 1, 1, 1, "release_glitch");  // e4
    drive(0, 1, 1, 1, "release_glitch");  // e5
    drive(0, 1, 1, 0, "release_glitch");  // e6 HIGH
    drive(0, 1, 1, 0, "release_glitch");  // e7

    // 5: clean release
    release_clean("clean_release");

    // 2: clean press, then release back to LOW
    press_clean("clean_press");
    release_clean("clean_release2");

    // 3: bounced press
    bounce_press("bounce_press");
    release_clean("bounce_release");

    // drop on the terminal-count cycle: glitch branch wins
    drive(0, 1, 0, 0, "last_cycle_glitch");  // e1
    drive(0, 1, 0, 0, "last_cycle_glitch");  // e2
    drive(0, 1, 0, 1, "last_cycle_glitch");  // e3 RISE cnt0
    drive(0, 1, 0, 1, "last_cycle_glitch");  // e4 cnt1
    drive(0, 0, 0, 1, "last_cycle_glitch");  // e5 cnt2
    drive(0, 0, 0, 1, "last_cycle_glitch");  // e6 cnt3
    drive(0, 0, 0, 0, "last_cycle_glitch");  // e7 LOW
    drive(0, 0, 0, 0, "last_cycle_glitch");
    drive(0, 0, 0, 0, "last_cycle_glitch");

    // 6: reset during RISE, fresh qualification afterwards
    drive(0, 1, 0, 0, "reset_mid_rise");  // e1
    drive(0, 1, 0, 0, "reset_mid_rise");  // e2
    drive(0, 1, 0, 1, "reset_mid_rise");  // e3 RISE cnt0
    drive(0, 1, 0, 1, "reset_mid_rise");  // e4 cnt1
    drive(1, 1, 0, 0, "reset_mid_rise");  // reset edge
    press_clean("after_mid_reset");
    release_clean("after_mid_reset_release");

    // 7: bounced press into rising detector gives exactly one 1-cycle pulse
    @(posedge clk);
    #3;
    count_pulses = 1'b1;
    bounce_press("chain_press");
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, "chain_hold");

    // let the monitor drain the scoreboard
    for (int i = 0; i < 3; i++) @(posedge clk);
    #3;
    count_pulses = 1'b0;
    total++;
    if (pulse_cycles != 1) begin
      bad++;
      $display("FAIL chain_pulse: got %0d pulse cycles, need 1", pulse_cycles);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // safety bound on run length
  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL timeout: got no completion, need completion by 200000");
      $fatal(1);
    end
  end

endmodule
